// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 signed int8 max-pool with optional ReLU, reading a conv output map
// one byte per cycle and writing pooled bytes into a host-readable buffer.
module maxpool2x2_stage #(
    parameter int DSIZE = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 in_width,
    input  logic [7:0]                 in_height,
    input  logic                       relu_en,
    output logic [$clog2(DSIZE):0]     src_addr,
    input  logic [31:0]                src_data,
    input  logic [$clog2(DSIZE):0]     po_addr,
    output logic [31:0]                po_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done
);
    localparam int AW = $clog2(DSIZE) + 1;
    localparam int PW = $clog2(DSIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [6:0]         r_ox;
    logic [6:0]         r_oy;
    logic [1:0]         r_ph;
    logic signed [7:0]  r_m;
    logic [7:0]         r_po [DSIZE];

    logic [6:0]         w_out_w;
    logic [6:0]         w_out_h;
    logic               w_degen;
    logic               w_run;
    logic               w_last_x;
    logic               w_last_y;
    logic               w_last_win;
    logic [7:0]         w_px;
    logic [7:0]         w_py;
    logic [15:0]        w_addr16;
    logic signed [7:0]  w_sample;
    logic signed [7:0]  w_max;
    logic [7:0]         w_result;
    logic [15:0]        w_po_waddr16;
    logic               w_po_we;
    logic               w_unused_bits;

    assign w_out_w    = in_width[7:1];
    assign w_out_h    = in_height[7:1];
    assign w_degen    = (w_out_w == 7'd0) || (w_out_h == 7'd0);
    assign w_run      = (r_state == S_RUN);
    assign w_last_x   = (r_ox == w_out_w - 7'd1);
    assign w_last_y   = (r_oy == w_out_h - 7'd1);
    assign w_last_win = (r_ph == 2'd3) && w_last_x && w_last_y;

    // Phase bit 0 selects the right column, bit 1 the lower row of the window.
    assign w_px     = {r_ox, r_ph[0]};
    assign w_py     = {r_oy, r_ph[1]};
    assign w_addr16 = 16'(w_px) + 16'(in_width) * 16'(w_py);
    assign src_addr = w_run ? w_addr16[AW-1:0] : '0;

    assign w_sample = src_data[7:0];
    assign w_max    = (w_sample > r_m) ? w_sample : r_m;
    assign w_result = (relu_en && w_max[7]) ? 8'd0 : w_max;

    assign w_po_waddr16 = 16'(r_ox) + 16'(w_out_w) * 16'(r_oy);
    assign w_po_we      = w_run && (r_ph == 2'd3);

    assign w_unused_bits = ^{src_data[31:8], po_addr[AW-1], in_height[0],
                             w_addr16[15:AW], w_po_waddr16[15:PW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_degen ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_win) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Window counters are held at zero outside RUN so every job starts at (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ox <= '0;
            r_oy <= '0;
            r_ph <= '0;
            r_m  <= '0;
        end else if (!w_run) begin
            r_ox <= '0;
            r_oy <= '0;
            r_ph <= '0;
            r_m  <= '0;
        end else begin
            r_ph <= r_ph + 2'd1;
            r_m  <= (r_ph == 2'd0) ? w_sample : w_max;
            if (r_ph == 2'd3) begin
                if (w_last_x) begin
                    r_ox <= '0;
                    r_oy <= r_oy + 7'd1;
                end else begin
                    r_ox <= r_ox + 7'd1;
                end
            end
        end
    end

    // The buffer deliberately survives reset; only completed windows overwrite it.
    always_ff @(posedge clk) begin
        if (w_po_we) begin
            r_po[w_po_waddr16[PW-1:0]] <= w_result;
        end
    end

    // Byte lanes wrap around the buffer end (DSIZE is a power of two).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_po_lane
            assign po_data[8*gi +: 8] = r_po[PW'(po_addr[PW-1:0] + PW'(gi))];
        end
    endgenerate

endmodule

// File: tb/tb_maxpool2x2_stage.sv
// Randomised scoreboard bench for maxpool2x2_stage: jobs push expected buffer images,
// a monitor checks each done pulse against them and watches address/reset behaviour.
module tb_maxpool2x2_stage;
    localparam int DSIZE = 256;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_width = '0;
    logic [7:0]    in_height = '0;
    logic          relu_en = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data;
    logic [AW-1:0] po_addr = '0;
    logic [31:0]   po_data;
    logic          busy;
    logic          done;

    logic [7:0]    src_mem [512];
    assign src_data = {24'hA5C3E1, src_mem[src_addr]};

    always #500 clk = ~clk;

    maxpool2x2_stage #(.DSIZE(DSIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_width  (in_width),
        .in_height (in_height),
        .relu_en   (relu_en),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .po_addr   (po_addr),
        .po_data   (po_data),
        .start     (start),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_po  [DSIZE];
    bit         ref_vld [DSIZE];

    typedef struct packed {
        logic [31:0]          cycles;
        logic [DSIZE*8-1:0]   img;
        logic [DSIZE-1:0]     vld;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
        end
    endtask

    function automatic logic [7:0] pool_byte(input int w, input int ox, input int oy, input bit relu);
        int m;
        int v;
        m = -1000;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = int'($signed(src_mem[(2*ox + dx) + w*(2*oy + dy)]));
                if (v > m) m = v;
            end
        end
        if (relu && m < 0) m = 0;
        return m[7:0];
    endfunction

    // Applies up to 'limit' windows of a job, in traversal order, to the reference buffer.
    task automatic model_job(input int w, input int h, input bit relu, input int limit);
        int ow;
        int oh;
        int k;
        int a;
        ow = w / 2;
        oh = h / 2;
        k = 0;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                if (k < limit) begin
                    a = (ox + ow*oy) % DSIZE;
                    ref_po[a]  = pool_byte(w, ox, oy, relu);
                    ref_vld[a] = 1'b1;
                    k++;
                end
            end
        end
    endtask

    task automatic push_exp(input int cycles);
        exp_t e;
        e.cycles = 32'(cycles);
        for (int i = 0; i < DSIZE; i++) begin
            e.img[i*8 +: 8] = ref_po[i];
            e.vld[i]        = ref_vld[i];
        end
        exp_q.push_back(e);
    endtask

    task automatic run_job(input int w, input int h, input bit relu, input bit restart);
        int n;
        int k;
        bit got;
        in_width  = 8'(w);
        in_height = 8'(h);
        relu_en   = relu;
        n = 4 * (w / 2) * (h / 2);
        model_job(w, h, relu, 1 << 30);
        push_exp(n);
        start = 1'b1;
        @(posedge clk);
        k = 1;
        got = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (k <= n + 20) begin
            #2;
            if (done) begin
                got = 1'b1;
                break;
            end
            start = restart && (k == 3);
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
        end
        check($sformatf("done_latency_%0dx%0d", w, h), got ? k : -1, n + 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) src_mem[i] = 8'($urandom);
    endtask

    // Monitor: reset values, legal source pixels, idle address, and buffer image on done.
    initial begin
        int bcnt;
        int x;
        int y;
        int idx;
        exp_t e;
        bcnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                bcnt = 0;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_src_addr", int'(src_addr), 0);
            end else begin
                if (busy) begin
                    bcnt++;
                    x = (in_width != 0) ? int'(src_addr) % int'(in_width) : 9999;
                    y = (in_width != 0) ? int'(src_addr) / int'(in_width) : 9999;
                    check($sformatf("src_pixel_legal_addr%0d", src_addr),
                          int'((x < 2*(in_width/2)) && (y < 2*(in_height/2))), 1);
                end else begin
                    check("idle_src_addr", int'(src_addr), 0);
                end
                if (done) begin
                    check("busy_during_done", int'(busy), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("busy_cycles", bcnt, int'(e.cycles));
                        for (int a = 0; a <= 256; a += 4) begin
                            po_addr = (a == 256) ? 9'd254 : AW'(a);
                            #1;
                            for (int b = 0; b < 4; b++) begin
                                idx = (int'(po_addr) + b) % DSIZE;
                                if (e.vld[idx]) begin
                                    check($sformatf("po_byte[%0d]", idx),
                                          int'(po_data[8*b +: 8]), int'(e.img[idx*8 +: 8]));
                                end
                            end
                        end
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        int w;
        int h;
        for (int i = 0; i < DSIZE; i++) begin
            ref_po[i]  = '0;
            ref_vld[i] = 1'b0;
        end
        for (int i = 0; i < 512; i++) src_mem[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4 ramp
        for (int i = 0; i < 16; i++) src_mem[i] = 8'(i);
        run_job(4, 4, 1'b0, 1'b0);

        // 4x2 negative values, without and with ReLU
        src_mem[0] = 8'hFB; src_mem[1] = 8'hFD; src_mem[2] = 8'hF8; src_mem[3] = 8'h80;
        src_mem[4] = 8'hFF; src_mem[5] = 8'hF9; src_mem[6] = 8'hFE; src_mem[7] = 8'h9C;
        run_job(4, 2, 1'b0, 1'b0);
        run_job(4, 2, 1'b1, 1'b0);

        // odd dimensions, degenerate start, restart attempt during RUN
        fill_random();
        run_job(5, 3, 1'b0, 1'b0);
        run_job(1, 4, 1'b0, 1'b0);
        fill_random();
        run_job(4, 4, 1'b1, 1'b1);

        // reset in the middle of a 4x4 job: only the first window lands
        fill_random();
        in_width = 8'd4; in_height = 8'd4; relu_en = 1'b0;
        model_job(4, 4, 1'b0, 1);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(4, 1, 1'b0, 1'b0);
        fill_random();
        run_job(4, 4, 1'b0, 1'b0);

        // saturated 16x16 with one minimum pixel
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h7F;
        src_mem[9 + 16*3] = 8'h80;
        run_job(16, 16, 1'b1, 1'b0);

        for (int j = 0; j < 8; j++) begin
            fill_random();
            w = $urandom_range(0, 22);
            h = $urandom_range(0, 22);
            run_job(w, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
